// File: rtl/register_file_2w2r.sv
// register_file_2w2r
// NUM_REGS x WIDTH register file with two combinational read ports and two
// clocked write ports. Sits between decode (register ids) and the ALU /
// writeback path (operands, results).
//
// Write rules:
//   - enabled, in-range writes commit at the rising edge
//   - when both ports target the same id, write2 wins
//   - a write to an unimplemented id changes nothing and raises access_error
//     for the following cycle only
//   - with ZERO_REG=1, register 0 reads 0 and writes to it are dropped silently
//
// Optional build macro: REGFILE_BYPASS_EN
//   When defined, a read whose id matches a committing write in the current
//   cycle returns the write data combinationally (write2 still wins, reset
//   suppresses it). When undefined, reads only ever see stored values.
module register_file_2w2r #(
    parameter int WIDTH    = 8,
    parameter int ID_WIDTH = 4,
    parameter int NUM_REGS = 12,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ID_WIDTH-1:0] read1_id,
    output logic [WIDTH-1:0]    read1_value,
    input  logic [ID_WIDTH-1:0] read2_id,
    output logic [WIDTH-1:0]    read2_value,
    input  logic                write1_enable,
    input  logic [ID_WIDTH-1:0] write1_id,
    input  logic [WIDTH-1:0]    write1_value,
    input  logic                write2_enable,
    input  logic [ID_WIDTH-1:0] write2_id,
    input  logic [WIDTH-1:0]    write2_value,
    output logic                access_error
);

    // One extra bit so NUM_REGS == 2**ID_WIDTH still compares correctly.
    localparam logic [ID_WIDTH:0] NUM_REGS_EXT = (ID_WIDTH+1)'(NUM_REGS);

    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic             r_accessError;

    logic w_write1InRange;
    logic w_write2InRange;
    logic w_write1Commit;
    logic w_write2Commit;
    logic w_accessErrorNext;

    function automatic logic isZeroReg(input logic [ID_WIDTH-1:0] id);
        return ZERO_REG && (id == '0);
    endfunction

    // Stored value for an id, zero for unimplemented ids or the hardwired
    // zero register, optionally overridden by this cycle's committing writes.
    function automatic logic [WIDTH-1:0] lookup(input logic [ID_WIDTH-1:0] id);
        logic [WIDTH-1:0] value;
        value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((id == ID_WIDTH'(i)) && !isZeroReg(id)) begin
                value = r_regs[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (!reset) begin
            if (w_write1Commit && (write1_id == id)) begin
                value = write1_value;
            end
            if (w_write2Commit && (write2_id == id)) begin
                value = write2_value;
            end
        end
`endif
        return value;
    endfunction

    // Classify each write port: in range, actually committing, or an error.
    always_comb begin
        w_write1InRange   = {1'b0, write1_id} < NUM_REGS_EXT;
        w_write2InRange   = {1'b0, write2_id} < NUM_REGS_EXT;
        w_write1Commit    = write1_enable && w_write1InRange && !isZeroReg(write1_id);
        w_write2Commit    = write2_enable && w_write2InRange && !isZeroReg(write2_id);
        w_accessErrorNext = (write1_enable && !w_write1InRange) ||
                            (write2_enable && !w_write2InRange);
    end

    // Register array and error flag; write2 takes priority on a shared id.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_accessError <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_write2Commit && (write2_id == ID_WIDTH'(i))) begin
                    r_regs[i] <= write2_value;
                end else if (w_write1Commit && (write1_id == ID_WIDTH'(i))) begin
                    r_regs[i] <= write1_value;
                end
            end
            r_accessError <= w_accessErrorNext;
        end
    end

    // Zero-latency read ports.
    always_comb begin
        read1_value = lookup(read1_id);
        read2_value = lookup(read2_id);
    end

    assign access_error = r_accessError;

endmodule

// File: doc/register_file_2w2r.md
Name: register_file_2w2r

Overview:
- Parametrised successor to the CPU's 8-bit register block: NUM_REGS registers of WIDTH bits, two combinational read ports, two clocked write ports.
- Adds over the previous generation: write enables, synchronous clear on reset, optional hardwired zero register, defined dual-write conflict rule, registered out-of-range access error flag.
- Sits between decode (register ids) and ALU / writeback (operands, results).

Parameters:
- WIDTH, 8, bits per register and per read/write value.
- ID_WIDTH, 4, width of every id port.
- NUM_REGS, 12, number of implemented registers. Ids 0..NUM_REGS-1. Must be at most 2**ID_WIDTH.
- ZERO_REG, 0, when 1, register 0 always reads 0 and writes to it are discarded silently.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- read1_id  input  ID_WIDTH  read port 1 register select.
- read1_value  output  WIDTH  read port 1 data.
- read2_id  input  ID_WIDTH  read port 2 register select.
- read2_value  output  WIDTH  read port 2 data.
- write1_enable  input  1  commit write1 at next rising edge.
- write1_id  input  ID_WIDTH  write port 1 register select.
- write1_value  input  WIDTH  write port 1 data.
- write2_enable  input  1  commit write2 at next rising edge.
- write2_id  input  ID_WIDTH  write port 2 register select.
- write2_value  input  WIDTH  write port 2 data.
- access_error  output  1  registered pulse: previous cycle had an enabled write to an unimplemented id.

Behaviour:
- One clock (clock). Reset is synchronous and active-high (reset). All state changes on the rising edge of clock only.
- Reset:
  - At a rising edge with reset=1, all registers become 0 and access_error becomes 0.
  - Writes presented in the same cycle are discarded.
  - Reset mid-operation (writes pending) gives the same result: every register reads 0 from the following cycle.
- Reads:
  - Purely combinational, zero latency. Value changes whenever the id or the addressed register changes.
  - id >= NUM_REGS reads 0.
  - id 0 reads 0 when ZERO_REG=1.
  - Both read ports may address the same register.
- Writes:
  - At a rising edge with reset=0, each enabled port writes its value to its id. Visible on reads after that edge (one-cycle latency, see Optional Feature).
  - A disabled port has no effect, whatever its id or value.
- Dual write, same id, both enabled: write2 wins and write1 is dropped; no error is raised.
- Dual write, different ids: both commit in the same cycle.
- Out-of-range write (enabled, id >= NUM_REGS):
  - No register changes.
  - access_error=1 for exactly the following cycle.
  - If both ports are out of range, still a single one-cycle pulse.
  - Back-to-back bad writes keep access_error high continuously.
- Write to register 0 with ZERO_REG=1: discarded, not an error.
- access_error is otherwise 0 and is cleared at the next edge.
- No other state; no state machine beyond the register array and the error flag.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose id matches an enabled, in-range, non-discarded write in the current cycle returns that write's value combinationally, before the edge.
  - The write2-wins rule applies to bypass as well.
  - Reset=1 suppresses bypass.
- Undefined:
  - Reads return the stored value only.
  - A same-cycle write is visible only after the rising edge.

Test Plan:
- Reset, then read1_id=3, read2_id=4 -> both values 8'h00. read1_id=14 -> 8'h00 (unimplemented).
- write1_enable=1, id=2, value=8'h55; before the edge read1_id=2 -> 8'h00 (8'h55 with REGFILE_BYPASS_EN). After the edge -> 8'h55; read2_id=3 -> 8'h00.
- Both ports enabled on id 5, write1=8'hAA, write2=8'h3C -> reg 5 reads 8'h3C after the edge, access_error=0.
- write1_enable=1, id=13, value=8'hFF -> access_error=1 for exactly one cycle, then 0; all registers unchanged. write2_enable=0 with id=13 -> no error.
- Load regs 1..11 with 8'h11..8'hBB; assert reset for one edge while write1 targets reg 7 with 8'h77 -> every register reads 8'h00 afterwards.
- ZERO_REG=1 build: write 8'h99 to id 0 -> read1_id=0 returns 8'h00, access_error stays 0.
